// File: rtl/cpu_params_pkg.sv
// Shared load/store constants: access size encodings, fault codes and the
// legality check used when a request is accepted.
package cpu_params_pkg;

  localparam int unsigned LS_ADDR_W = 32;

  localparam logic [2:0] SZ_BYTE = 3'd1;
  localparam logic [2:0] SZ_HALF = 3'd2;
  localparam logic [2:0] SZ_WORD = 3'd4;

  localparam int unsigned FAULT_MIS_BIT = 0;
  localparam int unsigned FAULT_BUS_BIT = 1;

  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_MIS  = 2'b01;
  localparam logic [1:0] FAULT_BUS  = 2'b10;

  // True when the size is supported and the address is naturally aligned for it.
  function automatic logic ls_legal(logic [2:0] size, logic [1:0] a);
    logic ok;
    ok = 1'b0;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~a[0];
      SZ_WORD: ok = (a == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cpu_structs_pkg.sv
// Load/store request record and controller state encoding.
package cpu_structs_pkg;

  import cpu_params_pkg::*;

  typedef struct packed {
    logic                 wr;
    logic [LS_ADDR_W-1:0] addr;
    logic [2:0]           size;
    logic                 mis;
    logic                 zero_ext;
    logic [31:0]          st_data;
  } ls_req_t;

  typedef enum logic [1:0] {IDLE, BUS, RESP} ls_state_t;

endpackage

// File: rtl/ls_lane_steer.sv
// Byte-lane steering: byte enables and replicated write data for stores,
// extraction plus sign/zero extension for loads.
module ls_lane_steer
  import cpu_params_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [2:0]  size_i,
  input  logic        zero_ext_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;
  logic        unused_shift;

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = st_data_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << addr_i;
        wdata_o = {2{st_data_i[15:0]}};
      end
      SZ_WORD: be_o = 4'b1111;
      default: ;
    endcase
  end

  // Move the addressed lane down to bit 0 before extending.
  always_comb begin
    shifted   = rdata_i >> {addr_i, 3'b000};
    ld_data_o = rdata_i;
    case (size_i)
      SZ_BYTE: ld_data_o = {{24{~zero_ext_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: ld_data_o = {{16{~zero_ext_i & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  assign unused_shift = ^shifted[31:16];

endmodule

// File: rtl/ls_mem_ctrl.sv
// MEM-stage load/store controller driving a single-outstanding req/ack data bus.
// Optional bus watchdog enabled by defining LS_BUS_TIMEOUT_EN.
module ls_mem_ctrl
  import cpu_params_pkg::*;
  import cpu_structs_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic              req_mis,
  input  logic              req_zero_ext,
  input  logic [31:0]       req_st_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_ld_data,
  output logic [1:0]        rsp_fault,
  output logic              dbus_req,
  output logic              dbus_rw,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_be,
  output logic [DATA_W-1:0] dbus_wdata,
  input  logic              dbus_ack,
  input  logic              dbus_err,
  input  logic [DATA_W-1:0] dbus_rdata
);

  ls_state_t   state_q, state_d;
  ls_req_t     req_q, req_d;
  logic        dbus_req_q, dbus_req_d;
  logic [31:0] rsp_ld_data_q, rsp_ld_data_d;
  logic [1:0]  rsp_fault_q, rsp_fault_d;

  logic [3:0]  steer_be;
  logic [31:0] steer_wdata;
  logic [31:0] steer_ld_data;
  logic        unused_mis;

`ifdef LS_BUS_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout;
  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

  ls_lane_steer u_lane_steer (
    .addr_i     (req_q.addr[1:0]),
    .size_i     (req_q.size),
    .zero_ext_i (req_q.zero_ext),
    .st_data_i  (req_q.st_data),
    .rdata_i    (32'(dbus_rdata)),
    .be_o       (steer_be),
    .wdata_o    (steer_wdata),
    .ld_data_o  (steer_ld_data)
  );

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    dbus_req_d    = dbus_req_q;
    rsp_ld_data_d = rsp_ld_data_q;
    rsp_fault_d   = rsp_fault_q;
`ifdef LS_BUS_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef LS_BUS_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (req_valid) begin
          req_d.wr       = req_wr;
          req_d.addr     = LS_ADDR_W'(req_addr);
          req_d.size     = req_size;
          req_d.mis      = req_mis;
          req_d.zero_ext = req_zero_ext;
          req_d.st_data  = req_st_data;
          if (!req_mis && ls_legal(req_size, req_addr[1:0])) begin
            state_d    = BUS;
            dbus_req_d = 1'b1;
          end else begin
            state_d       = RESP;
            rsp_fault_d   = FAULT_MIS;
            rsp_ld_data_d = '0;
          end
        end
      end
      BUS: begin
        if (dbus_err) begin
          state_d       = RESP;
          dbus_req_d    = 1'b0;
          rsp_fault_d   = FAULT_BUS;
          rsp_ld_data_d = '0;
        end else if (dbus_ack) begin
          state_d       = RESP;
          dbus_req_d    = 1'b0;
          rsp_fault_d   = FAULT_NONE;
          rsp_ld_data_d = req_q.wr ? '0 : steer_ld_data;
`ifdef LS_BUS_TIMEOUT_EN
        end else if (timeout) begin
          state_d       = RESP;
          dbus_req_d    = 1'b0;
          rsp_fault_d   = FAULT_BUS;
          rsp_ld_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d       = IDLE;
          rsp_fault_d   = FAULT_NONE;
          rsp_ld_data_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q       <= IDLE;
      req_q         <= '0;
      dbus_req_q    <= 1'b0;
      rsp_ld_data_q <= '0;
      rsp_fault_q   <= FAULT_NONE;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      dbus_req_q    <= dbus_req_d;
      rsp_ld_data_q <= rsp_ld_data_d;
      rsp_fault_q   <= rsp_fault_d;
    end
  end

`ifdef LS_BUS_TIMEOUT_EN
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Bus fields come straight from the captured request, so they stay stable while
  // dbus_req is high and read as zero otherwise.
  assign dbus_req   = dbus_req_q;
  assign dbus_rw    = dbus_req_q & req_q.wr;
  assign dbus_addr  = dbus_req_q ? ADDR_W'({req_q.addr[LS_ADDR_W-1:2], 2'b00}) : '0;
  assign dbus_be    = dbus_req_q ? steer_be : 4'b0000;
  assign dbus_wdata = dbus_req_q ? DATA_W'(steer_wdata) : '0;

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_ld_data = rsp_ld_data_q;
  assign rsp_fault   = rsp_fault_q;

  assign unused_mis = req_q.mis;

endmodule

// File: tb/tb_ls_mem_ctrl.sv
// Self-checking bench for ls_mem_ctrl: directed cases plus randomized transactions
// checked against an arithmetic reference model.
module tb_ls_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic        req_mis;
  logic        req_zero_ext;
  logic [31:0] req_st_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_ld_data;
  logic [1:0]  rsp_fault;
  logic        dbus_req;
  logic        dbus_rw;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic        dbus_err;
  logic [31:0] dbus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  ls_mem_ctrl #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_mis      (req_mis),
    .req_zero_ext (req_zero_ext),
    .req_st_data  (req_st_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_ld_data  (rsp_ld_data),
    .rsp_fault    (rsp_fault),
    .dbus_req     (dbus_req),
    .dbus_rw      (dbus_rw),
    .dbus_addr    (dbus_addr),
    .dbus_be      (dbus_be),
    .dbus_wdata   (dbus_wdata),
    .dbus_ack     (dbus_ack),
    .dbus_err     (dbus_err),
    .dbus_rdata   (dbus_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] model_ld(logic [31:0] rd, logic [1:0] a, logic [2:0] sz,
                                           logic zx);
    logic [31:0] v;
    if (sz == 3'd4) return rd;
    v = rd >> (int'(a) * 8);
    if (sz == 3'd1) begin
      v = v & 32'hFF;
      if (!zx && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else begin
      v = v & 32'hFFFF;
      if (!zx && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_be(logic [1:0] a, logic [2:0] sz);
    int unsigned m;
    m = (1 << int'(sz)) - 1;
    return 32'(m << int'(a));
  endfunction

  function automatic logic [31:0] model_wdata(logic [31:0] st, logic [2:0] sz);
    if (sz == 3'd1) return (st & 32'hFF) * 32'h0101_0101;
    if (sz == 3'd2) return (st & 32'hFFFF) * 32'h0001_0001;
    return st;
  endfunction

  task automatic present(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic mis, input logic zext, input logic [31:0] st);
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_wr       = wr;
    req_addr     = addr;
    req_size     = size;
    req_mis      = mis;
    req_zero_ext = zext;
    req_st_data  = st;
    step();
    req_valid = 1'b0;
    req_addr  = $urandom;
    check_eq("req_ready_busy", 32'(req_ready), 32'd0);
  endtask

  // Full transaction: accept, bus phase with waits, response held for `hold` cycles.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic mis, input logic zext, input logic [31:0] st,
                         input logic [31:0] rdata, input int waits, input logic err,
                         input logic ack_with_err, input int hold);
    logic        bad;
    logic [31:0] exp_ld;
    logic [31:0] exp_flt;
    bad = mis || !(size == 3'd1 || size == 3'd2 || size == 3'd4) ||
          (size == 3'd2 && addr[0]) || (size == 3'd4 && addr[1:0] != 2'b00);
    present(wr, addr, size, mis, zext, st);
    if (bad) begin
      check_eq("mis_no_bus", 32'(dbus_req), 32'd0);
      exp_ld  = 32'd0;
      exp_flt = 32'd1;
    end else begin
      check_eq("bus_req", 32'(dbus_req), 32'd1);
      check_eq("bus_rw", 32'(dbus_rw), 32'(wr));
      check_eq("bus_addr", dbus_addr, addr & 32'hFFFF_FFFC);
      check_eq("bus_be", 32'(dbus_be), model_be(addr[1:0], size));
      if (wr) check_eq("bus_wdata", dbus_wdata, model_wdata(st, size));
      for (int w = 0; w < waits; w++) begin
        step();
        check_eq("bus_hold_req", 32'(dbus_req), 32'd1);
        check_eq("bus_hold_addr", dbus_addr, addr & 32'hFFFF_FFFC);
        check_eq("bus_no_rsp", 32'(rsp_valid), 32'd0);
      end
      dbus_rdata = rdata;
      if (err) begin
        dbus_err = 1'b1;
        dbus_ack = ack_with_err;
      end else begin
        dbus_ack = 1'b1;
      end
      step();
      dbus_ack   = 1'b0;
      dbus_err   = 1'b0;
      dbus_rdata = $urandom;
      check_eq("bus_released", 32'(dbus_req), 32'd0);
      exp_flt = err ? 32'd2 : 32'd0;
      exp_ld  = (err || wr) ? 32'd0 : model_ld(rdata, addr[1:0], size, zext);
    end
    check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("rsp_ld_data", rsp_ld_data, exp_ld);
    check_eq("rsp_fault", 32'(rsp_fault), exp_flt);
    for (int h = 0; h < hold; h++) begin
      dbus_ack = 1'($urandom_range(0, 1));
      step();
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_ld_data", rsp_ld_data, exp_ld);
      check_eq("hold_fault", 32'(rsp_fault), exp_flt);
      check_eq("hold_req_ready", 32'(req_ready), 32'd0);
      check_eq("hold_no_bus", 32'(dbus_req), 32'd0);
    end
    dbus_ack  = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq("b2b_req_ready", 32'(req_ready), 32'd1);
    check_eq("rsp_dropped", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [2:0]  size;
    logic [31:0] addr;
    logic        mis;
    logic [2:0]  illegal_sz [5];
    int          cycles;

    illegal_sz = '{3'd0, 3'd3, 3'd5, 3'd6, 3'd7};
    reset_in = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_size = 3'd4;
    req_mis = 1'b0; req_zero_ext = 1'b0; req_st_data = '0; rsp_ready = 1'b0;
    dbus_ack = 1'b0; dbus_err = 1'b0; dbus_rdata = '0;
    repeat (3) step();
    reset_in = 1'b0;

    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_dbus_req", 32'(dbus_req), 32'd0);
    check_eq("rst_dbus_rw", 32'(dbus_rw), 32'd0);
    check_eq("rst_dbus_addr", dbus_addr, 32'd0);
    check_eq("rst_dbus_be", 32'(dbus_be), 32'd0);
    check_eq("rst_dbus_wdata", dbus_wdata, 32'd0);
    check_eq("rst_ld_data", rsp_ld_data, 32'd0);
    check_eq("rst_fault", 32'(rsp_fault), 32'd0);

    // LB sign-extended from the top lane
    run_txn(1'b0, 32'h1003, 3'd1, 1'b0, 1'b0, 32'h0, 32'h80AA_BBCC, 0, 1'b0, 1'b0, 0);
    // LHU upper half
    run_txn(1'b0, 32'h2002, 3'd2, 1'b0, 1'b1, 32'h0, 32'h9123_4567, 1, 1'b0, 1'b0, 1);
    // SB with minimum latency
    run_txn(1'b1, 32'h3001, 3'd1, 1'b0, 1'b0, 32'h0000_00A5, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 0);
    // Misaligned LW, response held five cycles
    run_txn(1'b0, 32'h4002, 3'd4, 1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 5);
    // Bus error after three waits
    run_txn(1'b0, 32'h5000, 3'd4, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 3, 1'b1, 1'b0, 2);

    // Reset in BUS, then a stray ack in IDLE
    present(1'b0, 32'h6004, 3'd4, 1'b0, 1'b0, 32'h0);
    check_eq("abort_bus_req", 32'(dbus_req), 32'd1);
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    check_eq("abort_req_drop", 32'(dbus_req), 32'd0);
    check_eq("abort_idle", 32'(req_ready), 32'd1);
    dbus_ack = 1'b1;
    dbus_rdata = 32'hCAFE_F00D;
    step();
    dbus_ack = 1'b0;
    check_eq("stray_ack_rsp", 32'(rsp_valid), 32'd0);
    check_eq("stray_ack_ready", 32'(req_ready), 32'd1);
    check_eq("stray_ack_bus", 32'(dbus_req), 32'd0);

    // Reset in RESP discards the response
    present(1'b0, 32'h7001, 3'd4, 1'b1, 1'b0, 32'h0);
    check_eq("resp_before_rst", 32'(rsp_valid), 32'd1);
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    check_eq("resp_discarded", 32'(rsp_valid), 32'd0);
    check_eq("resp_rst_fault", 32'(rsp_fault), 32'd0);
    check_eq("resp_rst_ready", 32'(req_ready), 32'd1);

    // Ack never arrives
    present(1'b0, 32'h8000, 3'd4, 1'b0, 1'b0, 32'h0);
    cycles = 0;
`ifdef LS_BUS_TIMEOUT_EN
    while (dbus_req && cycles < 200) begin
      cycles++;
      step();
    end
    check_eq("timeout_cycles", 32'(cycles), 32'd8);
    check_eq("timeout_rsp", 32'(rsp_valid), 32'd1);
    check_eq("timeout_fault", 32'(rsp_fault), 32'd2);
    check_eq("timeout_ld", rsp_ld_data, 32'd0);
    dbus_ack = 1'b1;
    step();
    dbus_ack = 1'b0;
    check_eq("late_ack_fault", 32'(rsp_fault), 32'd2);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq("timeout_idle", 32'(req_ready), 32'd1);
`else
    while (dbus_req && cycles < 120) begin
      cycles++;
      step();
    end
    check_eq("no_timeout_cycles", 32'(cycles), 32'd120);
    check_eq("no_timeout_rsp", 32'(rsp_valid), 32'd0);
    dbus_ack   = 1'b1;
    dbus_rdata = 32'h0BAD_CAFE;
    step();
    dbus_ack = 1'b0;
    check_eq("late_ack_ld", rsp_ld_data, 32'h0BAD_CAFE);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq("late_ack_idle", 32'(req_ready), 32'd1);
`endif

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: size = 3'd1;
        3, 4, 5: size = 3'd2;
        6, 7, 8: size = 3'd4;
        default: size = illegal_sz[$urandom_range(0, 4)];
      endcase
      addr = $urandom;
      if ($urandom_range(0, 99) < 85) begin
        if (size == 3'd2) addr[0] = 1'b0;
        if (size == 3'd4) addr[1:0] = 2'b00;
      end
      mis = (size == 3'd2 && addr[0]) || (size == 3'd4 && addr[1:0] != 2'b00) ||
            ($urandom_range(0, 19) == 0);
      run_txn(1'($urandom_range(0, 1)), addr, size, mis, 1'($urandom_range(0, 1)), $urandom,
              $urandom, int'($urandom_range(0, 3)), ($urandom_range(0, 6) == 0),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ls_mem_ctrl.md
Name: ls_mem_ctrl

Overview:
- MEM-stage responder for load/store requests produced by the EXE-stage load/store functional unit: consumes address, size, misalign flag, zero-extend flag and store data.
- Drives a single-outstanding word-oriented data bus (req/ack) with byte enables and lane-steered write data.
- Returns load data aligned to bit 0 and sign/zero extended.
- Sits between the EXE→MEM pipeline register and the data-memory/bus arbiter.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data bus width (fixed 32; 4 byte lanes)
- TIMEOUT_CYCLES, 64, bus watchdog limit (used only with the optional feature)

Ports:
- clk_in  input  1  clock
- reset_in  input  1  synchronous active-high reset
- req_valid  input  1  MEM stage presents a load/store
- req_ready  output  1  controller accepts the request this cycle
- req_wr  input  1  1=store, 0=load
- req_addr  input  ADDR_W  byte address
- req_size  input  3  1, 2 or 4 bytes
- req_mis  input  1  misalignment flag from EXE
- req_zero_ext  input  1  1=LBU/LHU
- req_st_data  input  32  store data, right-aligned
- rsp_valid  output  1  response available
- rsp_ready  input  1  MEM stage consumes the response
- rsp_ld_data  output  32  extended load data; 0 for stores and faults
- rsp_fault  output  2  bit0 misaligned, bit1 bus error/timeout
- dbus_req  output  1  bus request, held until ack/err
- dbus_rw  output  1  1=write
- dbus_addr  output  ADDR_W  word address, bits[1:0]=0
- dbus_be  output  4  byte enables
- dbus_wdata  output  32  lane-steered write data
- dbus_ack  input  1  transfer complete
- dbus_err  input  1  transfer error, same cycle as ack or instead of it
- dbus_rdata  input  32  read data, valid with ack

Behaviour:
- Reset (synchronous): state=IDLE. All outputs 0 except req_ready=1.
- FSM:
  - IDLE → BUS on req_valid with a legal, aligned request.
  - IDLE → RESP on req_valid when req_mis=1 or req_size∉{1,2,4}: rsp_fault=01, no bus cycle.
  - BUS → RESP on dbus_ack or dbus_err.
  - RESP → IDLE on rsp_ready.
- req_ready=1 only in IDLE. The request is accepted when req_valid & req_ready, and all request fields are registered at acceptance.
- dbus_* outputs are registered. dbus_req rises the cycle after acceptance and stays high, with addr/be/wdata/rw stable, until ack or err is sampled.
- Byte enables, with a=addr[1:0]:
  - size1: be=0001<<a
  - size2: be=0011<<a, a∈{0,2}
  - size4: be=1111
- Write data: st_data replicated across lanes (byte ×4, half ×2); dbus_rdata is ignored on writes.
- Load extraction:
  - Byte = rdata[8a+7:8a].
  - Half = rdata[8a+15:8a].
  - Sign extension from the msb unless zero_ext=1. Size4 passes rdata through.
- rsp_ld_data is registered on ack. Minimum latency: accept at cycle 0, dbus_req at cycle 1, ack at cycle 1, rsp_valid at cycle 2.
- dbus_err sampled (with or without ack) → rsp_fault=10 and rsp_ld_data=0.
- In RESP, rsp_valid, rsp_ld_data and rsp_fault are held stable until rsp_ready. Back-to-back: rsp_ready at cycle n gives req_ready=1 at cycle n+1.
- dbus_ack/dbus_err while not in BUS are ignored.
- Reset mid-BUS: dbus_req drops the next edge. A late ack for the aborted transfer arrives in IDLE and is ignored.
- Reset mid-RESP: the response is discarded.

Optional Feature:
- Macro LS_BUS_TIMEOUT_EN.
- Defined:
  - A counter is cleared on entry to BUS and increments each BUS cycle without ack/err.
  - Reaching TIMEOUT_CYCLES-1 forces dbus_req low next edge, enters RESP with rsp_fault=10.
  - A late ack/err arriving in RESP or IDLE is ignored.
- Undefined: no counter; BUS waits for ack/err indefinitely.

Decomposition:
- cpu_params_pkg holds the size encodings (SZ_BYTE=1, SZ_HALF=2, SZ_WORD=4) and the fault bit constants.
- cpu_structs_pkg holds the ls_req_t struct (wr, addr, size, mis, zero_ext, st_data) and the ls_state_t enum {IDLE, BUS, RESP}.
- One combinational sub-module, ls_lane_steer: computes be and wdata from addr/size/st_data, and ld_data from rdata/addr/size/zero_ext.
- Controller FSM and registers live in ls_mem_ctrl.

Test Plan:
- LB addr=0x1003, rdata=0x80AA_BBCC, zero_ext=0 → dbus_addr=0x1000, be=1000, rsp_ld_data=0xFFFFFF80, fault=00.
- LHU addr=0x2002, rdata=0x9123_4567 → be=1100, rsp_ld_data=0x00009123.
- SB addr=0x3001, st_data=0x000000A5 → be=0010, wdata=0xA5A5A5A5, dbus_rw=1; ack at cycle 1 → rsp_valid at cycle 2.
- LW with req_mis=1, addr=0x4002 → dbus_req never asserts, rsp_valid next cycle, fault=01; with rsp_ready held low 5 cycles, outputs stay stable and req_ready=0.
- Load with dbus_err=1 after 3 wait cycles → fault=10, rsp_ld_data=0. Then reset_in in BUS → dbus_req=0 next cycle, and a following stray ack is ignored.
- With LS_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, ack never arrives → dbus_req deasserts after 8 BUS cycles, fault=10. Without the macro, dbus_req stays high for 100+ cycles.
